// File: rtl/mspeckey_pkg.sv
// Shared definitions for the iterative mSPECKEY decryption layer: default lane
// geometry, the FSM state enum and the half-lane rotate helpers.
package mspeckey_pkg;

    localparam int DEF_LANE_W = 16;
    localparam int DEF_HALF_W = DEF_LANE_W / 2;
    localparam int DEF_ALPHA  = 7;
    localparam int DEF_BETA   = 2;
    localparam int MAX_HALF_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_state_e;

    // Rotates the low w bits of v. The bits above w are returned as zero.
    function automatic logic [MAX_HALF_W-1:0] rol_half(input logic [MAX_HALF_W-1:0] v,
                                                       input int amt, input int w);
        logic [MAX_HALF_W-1:0] mask;
        mask = {MAX_HALF_W{1'b1}} >> (MAX_HALF_W - w);
        return (((v & mask) << amt) | ((v & mask) >> (w - amt))) & mask;
    endfunction

    function automatic logic [MAX_HALF_W-1:0] ror_half(input logic [MAX_HALF_W-1:0] v,
                                                       input int amt, input int w);
        return rol_half(v, w - amt, w);
    endfunction

endpackage

// File: rtl/mspeckey_dec_round.sv
// One keyless inverse mSPECKEY round on a single lane; purely combinational.
module mspeckey_dec_round
    import mspeckey_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W,
    parameter int ALPHA  = DEF_ALPHA,
    parameter int BETA   = DEF_BETA
) (
    input  logic [LANE_W-1:0] lane_i,
    output logic [LANE_W-1:0] lane_o
);

    localparam int HALF_W = LANE_W / 2;

    if ((LANE_W % 2) != 0 || HALF_W > MAX_HALF_W) begin : g_bad_width
        $error("mspeckey_dec_round: LANE_W must be even and at most 2*MAX_HALF_W");
    end

    logic [HALF_W-1:0]     x, y, y_new, diff, x_new;
    logic [MAX_HALF_W-1:0] y_rot, x_rot;
    logic                  unused_hi;

    assign x = lane_i[LANE_W-1:HALF_W];
    assign y = lane_i[HALF_W-1:0];

    assign y_rot = ror_half(MAX_HALF_W'(y ^ x), BETA, HALF_W);
    assign y_new = y_rot[HALF_W-1:0];
    assign diff  = x - y_new;
    assign x_rot = rol_half(MAX_HALF_W'(diff), ALPHA, HALF_W);
    assign x_new = x_rot[HALF_W-1:0];

    // Upper bits of the helper results are always zero.
    assign unused_hi = ^{y_rot, x_rot};

    assign lane_o = {x_new, y_new};

endmodule

// File: rtl/mspeckey_dec_warx_iter.sv
// Iterative multi-lane mSPECKEY decryption layer, one round (two with
// MSPECKEY_DEC_UNROLL2_EN defined) per clock behind valid/ready handshakes.
module mspeckey_dec_warx_iter
    import mspeckey_pkg::*;
#(
    parameter int N_LANES    = 8,
    parameter int LANE_W     = DEF_LANE_W,
    parameter int ALPHA      = DEF_ALPHA,
    parameter int BETA       = DEF_BETA,
    parameter int NUM_ROUNDS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_LANES*LANE_W-1:0]   state_i,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_LANES*LANE_W-1:0]   state_o,
    output logic                        busy
);

    localparam int STATE_W = N_LANES * LANE_W;
    localparam int CNT_W   = $clog2(NUM_ROUNDS + 1);
`ifdef MSPECKEY_DEC_UNROLL2_EN
    localparam int STEP    = 2;
`else
    localparam int STEP    = 1;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(STEP);

    if (NUM_ROUNDS < 1 || (NUM_ROUNDS % STEP) != 0) begin : g_bad_rounds
        $error("mspeckey_dec_warx_iter: NUM_ROUNDS must be >= 1 and a multiple of the round step");
    end

    fsm_state_e          state_q, state_d;
    logic [STATE_W-1:0]  data_q, data_d, round_out;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
`ifdef MSPECKEY_DEC_UNROLL2_EN
        logic [LANE_W-1:0] mid;

        mspeckey_dec_round #(.LANE_W(LANE_W), .ALPHA(ALPHA), .BETA(BETA)) u_round0 (
            .lane_i (data_q[k*LANE_W +: LANE_W]),
            .lane_o (mid)
        );
        mspeckey_dec_round #(.LANE_W(LANE_W), .ALPHA(ALPHA), .BETA(BETA)) u_round1 (
            .lane_i (mid),
            .lane_o (round_out[k*LANE_W +: LANE_W])
        );
`else
        mspeckey_dec_round #(.LANE_W(LANE_W), .ALPHA(ALPHA), .BETA(BETA)) u_round0 (
            .lane_i (data_q[k*LANE_W +: LANE_W]),
            .lane_o (round_out[k*LANE_W +: LANE_W])
        );
`endif
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = state_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                data_d = round_out;
                cnt_d  = cnt_q + CNT_STEP;
                if (cnt_d == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        // Handing off and reloading on the same edge keeps the pipe bubble-free.
                        data_d  = state_i;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign state_o   = data_q;

endmodule

// File: tb/tb_mspeckey_dec_warx_iter.sv
// Self-checking bench for mspeckey_dec_warx_iter against an arithmetic lane model;
// expected latencies follow MSPECKEY_DEC_UNROLL2_EN when it is defined.
module tb_mspeckey_dec_warx_iter;

`ifdef MSPECKEY_DEC_UNROLL2_EN
    localparam int R1     = 2;
    localparam int UNROLL = 1;
`else
    localparam int R1     = 1;
    localparam int UNROLL = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv   [4];
    logic         ir   [4];
    logic         ov   [4];
    logic         ordy [4];
    logic         bsy  [4];
    logic [127:0] sin  [4];
    logic [127:0] sout [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mspeckey_dec_warx_iter #(.N_LANES(8), .LANE_W(16), .ALPHA(7), .BETA(2), .NUM_ROUNDS(R1)) dut_r1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .state_i(sin[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .state_o(sout[0]), .busy(bsy[0]));
    mspeckey_dec_warx_iter #(.N_LANES(8), .LANE_W(16), .ALPHA(7), .BETA(2), .NUM_ROUNDS(4)) dut_r4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .state_i(sin[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .state_o(sout[1]), .busy(bsy[1]));
    mspeckey_dec_warx_iter #(.N_LANES(8), .LANE_W(16), .ALPHA(7), .BETA(2), .NUM_ROUNDS(8)) dut_r8 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .state_i(sin[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .state_o(sout[2]), .busy(bsy[2]));
    mspeckey_dec_warx_iter #(.N_LANES(4), .LANE_W(32), .ALPHA(8), .BETA(3), .NUM_ROUNDS(6)) dut_w32 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .state_i(sin[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .state_o(sout[3]), .busy(bsy[3]));

    // ---------------- reference model ----------------
    function automatic int lane_w(int d);  return (d == 3) ? 32 : 16; endfunction
    function automatic int alpha_of(int d); return (d == 3) ? 8 : 7; endfunction
    function automatic int beta_of(int d);  return (d == 3) ? 3 : 2; endfunction
    function automatic int rounds_of(int d);
        case (d)
            0: return R1;
            1: return 4;
            2: return 8;
            default: return 6;
        endcase
    endfunction
    function automatic int lat_exp(int d);
        return (UNROLL != 0) ? rounds_of(d) / 2 : rounds_of(d);
    endfunction

    function automatic longint unsigned rotl(longint unsigned v, int a, int w);
        longint unsigned m = 64'd1 << w;
        return ((v * (64'd1 << a)) % m) + (v / (64'd1 << (w - a)));
    endfunction
    function automatic longint unsigned rotr(longint unsigned v, int a, int w);
        return rotl(v, w - a, w);
    endfunction

    function automatic longint unsigned dec_lane(int d, longint unsigned v);
        int h = lane_w(d) / 2;
        longint unsigned m = 64'd1 << h;
        longint unsigned x = v / m, y = v % m, yn, xn;
        yn = rotr(x ^ y, beta_of(d), h);
        xn = rotl((x + m - yn) % m, alpha_of(d), h);
        return xn * m + yn;
    endfunction

    function automatic longint unsigned enc_lane(int d, longint unsigned v);
        int h = lane_w(d) / 2;
        longint unsigned m = 64'd1 << h;
        longint unsigned x = v / m, y = v % m;
        x = (rotr(x, alpha_of(d), h) + y) % m;
        y = rotl(y, beta_of(d), h) ^ x;
        return x * m + y;
    endfunction

    function automatic logic [127:0] model(int d, logic [127:0] s, bit fwd);
        int w = lane_w(d);
        logic [127:0] mask = (128'd1 << w) - 128'd1;
        logic [127:0] res = '0, lane;
        longint unsigned v;
        for (int k = 0; k < 128 / w; k++) begin
            lane = (s >> (k * w)) & mask;
            v = lane[63:0];
            for (int r = 0; r < rounds_of(d); r++) v = fwd ? enc_lane(d, v) : dec_lane(d, v);
            res = res | (128'(v) << (k * w));
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete transaction; starts and ends on a negedge with the DUT idle.
    task automatic run_txn(input int d, input logic [127:0] s, output logic [127:0] res,
                           output int lat, output bit ok);
        iv[d] = 1'b1; sin[d] = s; ordy[d] = 1'b0;
        @(negedge clk);
        iv[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ok  = ov[d];
        res = sout[d];
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_cmp++; if (ir[0] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", ir[0]); end
        n_cmp++; if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", ov[0]); end
        n_cmp++; if (bsy[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", bsy[0]); end
        n_cmp++; if (sout[0] !== 128'd0) begin n_bad++; $display("FAIL reset_state got=%h want=0", sout[0]); end
        iv[0] = 1'b1; sin[0] = rand128(); ordy[0] = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (lat_exp(0)) @(negedge clk);
        n_cmp++; if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL prereset_done got=%b want=1", ov[0]); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (ir[0] !== 1'b1) begin n_bad++; $display("FAIL async_rst_in_ready got=%b want=1", ir[0]); end
        n_cmp++; if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL async_rst_out_valid got=%b want=0", ov[0]); end
        n_cmp++; if (bsy[0] !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy got=%b want=0", bsy[0]); end
        n_cmp++; if (sout[0] !== 128'd0) begin n_bad++; $display("FAIL async_rst_state got=%h want=0", sout[0]); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_round();
        logic [127:0] vec [5];
        logic [127:0] res, exp;
        int lat;
        bit ok;
        vec[0] = {8{16'h0100}};
        vec[1] = '0;
        for (int i = 2; i < 5; i++) vec[i] = rand128();
        for (int i = 0; i < 5; i++) begin
            run_txn(0, vec[i], res, lat, ok);
            exp = model(0, vec[i], 1'b0);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout[%0d] out_valid never rose", i); end
            n_cmp++; if (lat != lat_exp(0)) begin n_bad++; $display("FAIL single_latency[%0d] got=%0d want=%0d", i, lat, lat_exp(0)); end
            n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL single_result[%0d] got=%h want=%h", i, res, exp); end
`ifndef MSPECKEY_DEC_UNROLL2_EN
            if (i == 0) begin
                n_cmp++; if (res !== {8{16'hE040}}) begin n_bad++; $display("FAIL single_e040 got=%h want=%h", res, {8{16'hE040}}); end
            end
`endif
            if (i == 1) begin
                n_cmp++; if (res !== 128'd0) begin n_bad++; $display("FAIL single_zero got=%h want=0", res); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a = rand128(), b = rand128(), exp_a, exp_b;
        int cnt;
        exp_a = model(0, a, 1'b0);
        exp_b = model(0, b, 1'b0);
        iv[0] = 1'b1; sin[0] = a; ordy[0] = 1'b0;
        @(negedge clk);
        sin[0] = b;
        cnt = 0;
        while (!ov[0] && cnt < 100) begin @(negedge clk); cnt++; end
        n_cmp++; if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL bp_timeout out_valid got=%b want=1", ov[0]); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (sout[0] !== exp_a) begin n_bad++; $display("FAIL bp_hold_state[%0d] got=%h want=%h", i, sout[0], exp_a); end
            n_cmp++; if (ir[0] !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, ir[0]); end
            n_cmp++; if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d] got=%b want=1", i, ov[0]); end
            @(negedge clk);
        end
        ordy[0] = 1'b1;
        #1;
        n_cmp++; if (ir[0] !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready got=%b want=1", ir[0]); end
        @(negedge clk);
        iv[0] = 1'b0; ordy[0] = 1'b0;
        n_cmp++; if (sout[0] !== b) begin n_bad++; $display("FAIL bp_reload_state got=%h want=%h", sout[0], b); end
        n_cmp++; if (bsy[0] !== 1'b1 || ov[0] !== 1'b0) begin n_bad++; $display("FAIL bp_reload_flags busy=%b out_valid=%b want 1/0", bsy[0], ov[0]); end
        cnt = 0;
        while (!ov[0] && cnt < 100) begin @(negedge clk); cnt++; end
        n_cmp++; if (sout[0] !== exp_b || ov[0] !== 1'b1) begin n_bad++; $display("FAIL bp_second_result got=%h valid=%b want=%h", sout[0], ov[0], exp_b); end
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] q [3];
        logic [127:0] res [$];
        int when [$];
        int sent = 0;
        for (int i = 0; i < 3; i++) q[i] = rand128();
        ordy[1] = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (ov[1]) begin res.push_back(sout[1]); when.push_back(cyc); end
            if (sent == 3 && res.size() == 3) break;
            if (sent < 3) begin
                iv[1] = 1'b1; sin[1] = q[sent];
                if (ir[1]) sent++;
            end else begin
                iv[1] = 1'b0;
            end
            @(negedge clk);
        end
        iv[1] = 1'b0; ordy[1] = 1'b0;
        n_cmp++; if (res.size() != 3) begin n_bad++; $display("FAIL b2b_count got=%0d want=3", res.size()); end
        for (int i = 0; i < 3 && i < res.size(); i++) begin
            n_cmp++; if (res[i] !== model(1, q[i], 1'b0)) begin n_bad++; $display("FAIL b2b_result[%0d] got=%h want=%h", i, res[i], model(1, q[i], 1'b0)); end
            n_cmp++; if (model(1, res[i], 1'b1) !== q[i]) begin n_bad++; $display("FAIL b2b_roundtrip[%0d] got=%h want=%h", i, model(1, res[i], 1'b1), q[i]); end
            if (i > 0) begin
                n_cmp++; if (when[i] - when[i-1] != lat_exp(1) + 1) begin n_bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", i, when[i] - when[i-1], lat_exp(1) + 1); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] y = rand128(), res;
        int lat, pulses = 0;
        bit ok;
        iv[2] = 1'b1; sin[2] = rand128(); ordy[2] = 1'b0;
        @(negedge clk);
        iv[2] = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bsy[2] !== 1'b1) begin n_bad++; $display("FAIL midrun_busy got=%b want=1", bsy[2]); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bsy[2] !== 1'b0 || ov[2] !== 1'b0 || ir[2] !== 1'b1) begin n_bad++; $display("FAIL midrun_abort busy=%b valid=%b ready=%b want 0/0/1", bsy[2], ov[2], ir[2]); end
        n_cmp++; if (sout[2] !== 128'd0) begin n_bad++; $display("FAIL midrun_state got=%h want=0", sout[2]); end
        @(negedge clk);
        rst = 1'b0;
        ordy[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ov[2]) pulses++;
            @(negedge clk);
        end
        ordy[2] = 1'b0;
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL midrun_no_pulse got=%0d want=0", pulses); end
        run_txn(2, y, res, lat, ok);
        n_cmp++; if (!ok || lat != lat_exp(2)) begin n_bad++; $display("FAIL midrun_next_latency got=%0d ok=%b want=%0d", lat, ok, lat_exp(2)); end
        n_cmp++; if (res !== model(2, y, 1'b0)) begin n_bad++; $display("FAIL midrun_next_result got=%h want=%h", res, model(2, y, 1'b0)); end
    endtask

    task automatic test_param_unroll();
        logic [127:0] s, res;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            s = rand128();
            run_txn(3, s, res, lat, ok);
            n_cmp++; if (!ok || lat != lat_exp(3)) begin n_bad++; $display("FAIL w32_latency[%0d] got=%0d ok=%b want=%0d", i, lat, ok, lat_exp(3)); end
            n_cmp++; if (res !== model(3, s, 1'b0)) begin n_bad++; $display("FAIL w32_result[%0d] got=%h want=%h", i, res, model(3, s, 1'b0)); end
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; sin[d] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_round();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_param_unroll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
